mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multicycle control sequencer for the MIPS CPU. Decodes `opcode`/`funct` into a registered state machine and drives the datapath: ALU operation `selector`, operand and PC source muxes, register-file and memory enables. Consumes the ALU `zeroFlag` for branches and handshakes with instruction/data memory through `mem_req`/`mem_ready`. ALU `selector` codes: 00 add, 01 sub, 10 and, 11 or.

## Interface
- No parameters; all widths fixed.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instruction bits [31:26]; valid from DECODE onward
- `funct`  in  6  instruction bits [5:0]
- `zeroFlag`  in  1  ALU zero result
- `mem_ready`  in  1  memory completes the current access this cycle
- `selector`  out  2  ALU operation
- `alu_src_A`  out  1  0=PC, 1=regA
- `alu_src_B`  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
- `pc_source`  out  2  00=ALU result, 01=ALUOut register, 10=jump target
- `pc_enable`  out  1  PC load; equals pc_write or (branch state and `zeroFlag`)
- `ir_write`  out  1  instruction register load
- `i_or_d`  out  1  memory address: 0=PC, 1=ALUOut
- `mem_req`  out  1  memory access request
- `mem_write`  out  1  write qualifier for `mem_req`
- `reg_write`  out  1  register-file write
- `reg_dst`  out  1  0=rt, 1=rd
- `mem_to_reg`  out  1  0=ALUOut, 1=MDR
- `state`  out  4  current state (debug)
- `illegal_op`  out  1  sticky trap flag (macro-dependent)

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, TRAP=12. Unused encodings 13–15 go to FETCH.
- FETCH: `mem_req`=1, `i_or_d`=0, A=0, B=01, `selector`=00, `pc_source`=00. `ir_write` and `pc_enable` equal `mem_ready`. Advance to DECODE on `mem_ready`; otherwise hold.
- DECODE: A=0, B=11, add. Next state by opcode:
  - 000000 with funct 100000/100010/100100/100101 → EXEC_R
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → EXEC_I
  - anything else → illegal (see Configuration)
- EXEC_R: A=1, B=00. `selector`: add→00, sub→01, and→10, or→11. Next R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next FETCH.
- MEM_ADDR: A=1, B=10, add. Next MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_req`=1, `i_or_d`=1. Hold until `mem_ready`, then MEM_WB.
- MEM_WRITE: `mem_req`=1, `mem_write`=1, `i_or_d`=1. Hold until `mem_ready`, then FETCH.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next FETCH.
- BRANCH: A=1, B=00, sub, `pc_source`=01, `pc_enable`=`zeroFlag`. Next FETCH.
- JUMP: `pc_source`=10, `pc_enable`=1. Next FETCH.
- EXEC_I: A=1, B=10, add. Next I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next FETCH.
- Any output not listed for a state is 0.

## Timing
- `state` and `illegal_op` are registered. Other outputs decode combinationally from `state`; `pc_enable` and `ir_write` are also combinational in `mem_ready`/`zeroFlag`.
- While `reset`=0: `state`=FETCH, `illegal_op`=0, and every control output is forced to 0. The first FETCH request is issued in the first cycle after release.
- Reset asserted mid-instruction: the state is abandoned immediately and the next access restarts at FETCH. No partial write completes after assertion.
- Cycle counts with zero-wait memory: beq/j 3, R-type/addi/sw 4, lw 5. Each low `mem_ready` cycle in FETCH/MEM_READ/MEM_WRITE adds one cycle.
- `mem_req` stays high and address/control are held stable until the `mem_ready` cycle. No new request is issued in the same cycle.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an illegal opcode/funct in DECODE goes to TRAP. TRAP holds all outputs 0 and sets `illegal_op`=1; both stay until reset.
- Undefined: an illegal instruction goes from DECODE to FETCH as a NOP. The TRAP encoding is unreachable and treated as unused; `illegal_op` is tied to 0.

## Test plan
- Reset release, `mem_ready`=1, add (opcode 0, funct 100000) → states 0,1,6,7,0. `selector`=00 in EXEC_R; `reg_write`=1 with `reg_dst`=1 in cycle 4.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total. `i_or_d`=1, `mem_req`=1 held for 3 cycles; `mem_to_reg`=1 in MEM_WB.
- beq with `zeroFlag`=1, then with `zeroFlag`=0 → `pc_enable`=1 (`pc_source`=01) vs 0 in BRANCH. `selector`=01 in both cases.
- sw (101011) → `mem_write`=1 only in MEM_WRITE. No `reg_write` during the instruction.
- opcode 111111 → with the macro: `state`=12, `illegal_op`=1 until reset. Without it: back to FETCH, `illegal_op`=0.
- Reset pulled low during MEM_WRITE wait → all outputs 0 at once, `state`=0. After release, a FETCH with `i_or_d`=0 is issued.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Multicycle control sequencer for a MIPS datapath. Decodes opcode/funct into
// a registered state machine and drives the datapath control signals, ALU
// operation, PC update and the memory request handshake.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   opcode      instruction bits [31:26], valid from DECODE onward
//   funct       instruction bits [5:0]
//   zeroFlag    ALU zero result (branch decision)
//   mem_ready   memory completes the current access this cycle
//   selector    ALU op: 00 add, 01 sub, 10 and, 11 or
//   alu_src_A   0=PC, 1=regA
//   alu_src_B   00=regB, 01=4, 10=signext imm, 11=signext imm<<2
//   pc_source   00=ALU result, 01=ALUOut, 10=jump target
//   pc_enable   PC load
//   ir_write    instruction register load
//   i_or_d      memory address: 0=PC, 1=ALUOut
//   mem_req     memory access request
//   mem_write   write qualifier for mem_req
//   reg_write   register-file write
//   reg_dst     0=rt, 1=rd
//   mem_to_reg  0=ALUOut, 1=MDR
//   state       current state (debug)
//   illegal_op  sticky trap flag
//
// Configuration macro: CTRL_ILLEGAL_TRAP_EN
//   defined   - illegal instructions enter TRAP, illegal_op sticks until reset
//   undefined - illegal instructions retire as NOPs, illegal_op tied to 0
//
// state      | meaning
// -----------+-----------------------------------------------
// FETCH  0   | read instruction at PC, PC += 4 on mem_ready
// DECODE 1   | register read, branch target into ALUOut
// MEM_ADDR 2 | effective address for lw/sw
// MEM_READ 3 | data read, held until mem_ready
// MEM_WB 4   | load data written to rt
// MEM_WRITE 5| data write, held until mem_ready
// EXEC_R 6   | R-type ALU operation
// R_WB 7     | R-type result written to rd
// BRANCH 8   | beq compare, PC <= ALUOut when equal
// JUMP 9     | PC <= jump target
// EXEC_I 10  | addi ALU operation
// I_WB 11    | addi result written to rt
// TRAP 12    | illegal instruction, parked until reset

module mips_multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zeroFlag,
    input  logic       mem_ready,
    output logic [1:0] selector,
    output logic       alu_src_A,
    output logic [1:0] alu_src_B,
    output logic [1:0] pc_source,
    output logic       pc_enable,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_req,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_I    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_TGT = S_TRAP;
`else
    localparam state_t ILLEGAL_TGT = S_FETCH;
`endif

    state_t state_q;
    state_t state_d;
    state_t decode_tgt;
    logic   funct_ok;

    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                      (funct == FN_AND) || (funct == FN_OR);

    always_comb begin
        decode_tgt = ILLEGAL_TGT;
        case (opcode)
            OP_RTYPE:     decode_tgt = funct_ok ? S_EXEC_R : ILLEGAL_TGT;
            OP_LW, OP_SW: decode_tgt = S_MEM_ADDR;
            OP_BEQ:       decode_tgt = S_BRANCH;
            OP_J:         decode_tgt = S_JUMP;
            OP_ADDI:      decode_tgt = S_EXEC_I;
            default:      decode_tgt = ILLEGAL_TGT;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = decode_tgt;
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    state_d = S_R_WB;
            S_EXEC_I:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB:
                         state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:      state_d = S_TRAP;
`endif
            // Unused encodings (and TRAP when trapping is disabled) recover.
            default:     state_d = S_FETCH;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
        end
    end

    assign illegal_op = illegal_q;
`else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign illegal_op = 1'b0;
`endif

    assign state = state_q;

    always_comb begin
        selector   = 2'b00;
        alu_src_A  = 1'b0;
        alu_src_B  = 2'b00;
        pc_source  = 2'b00;
        pc_enable  = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_B = 2'b01;
                ir_write  = mem_ready;
                pc_enable = mem_ready;
            end
            S_DECODE: alu_src_B = 2'b11;
            S_MEM_ADDR: begin
                alu_src_A = 1'b1;
                alu_src_B = 2'b10;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_A = 1'b1;
                case (funct)
                    FN_SUB:  selector = 2'b01;
                    FN_AND:  selector = 2'b10;
                    FN_OR:   selector = 2'b11;
                    default: selector = 2'b00;
                endcase
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_A = 1'b1;
                selector  = 2'b01;
                pc_source = 2'b01;
                pc_enable = zeroFlag;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_enable = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_A = 1'b1;
                alu_src_B = 2'b10;
            end
            S_I_WB: reg_write = 1'b1;
            default: ;
        endcase
        // Reset silences the datapath immediately, before the state register
        // has a clock edge to react; this is what kills a pending write.
        if (!reset) begin
            selector   = 2'b00;
            alu_src_A  = 1'b0;
            alu_src_B  = 2'b00;
            pc_source  = 2'b00;
            pc_enable  = 1'b0;
            ir_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control. Each instruction is turned
// into an expected per-cycle trace (outputs plus the mem_ready to drive) built
// from the instruction's class and the memory wait pattern; the DUT is then
// compared against that trace on every cycle. Honours CTRL_ILLEGAL_TRAP_EN.
module tb_mips_multicycle_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zeroFlag;
    logic       mem_ready;
    logic [1:0] selector;
    logic       alu_src_A;
    logic [1:0] alu_src_B;
    logic [1:0] pc_source;
    logic       pc_enable;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_req;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [3:0] state;
    logic       illegal_op;

    mips_multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .zeroFlag(zeroFlag), .mem_ready(mem_ready), .selector(selector),
        .alu_src_A(alu_src_A), .alu_src_B(alu_src_B), .pc_source(pc_source),
        .pc_enable(pc_enable), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_req(mem_req), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] sel;
        logic       a;
        logic [1:0] b;
        logic [1:0] pcs;
        logic       pce;
        logic       irw;
        logic       iod;
        logic       req;
        logic       wr;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ill;
    } outs_t;

    typedef struct {
        outs_t exp;
        logic  mr;
    } step_t;

    outs_t      act;
    step_t      tr[$];
    logic [3:0] hist[$];
    int         n_checks = 0;
    int         n_errors = 0;

    logic [3:0] want_add [0:3] = '{4'd0, 4'd1, 4'd6, 4'd7};
    logic [3:0] want_lw  [0:6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};

    assign act = {state, selector, alu_src_A, alu_src_B, pc_source, pc_enable,
                  ir_write, i_or_d, mem_req, mem_write, reg_write, reg_dst,
                  mem_to_reg, illegal_op};

    function automatic outs_t blank(logic [3:0] st);
        outs_t v = '0;
        v.st = st;
        return v;
    endfunction

    function automatic void push(outs_t e, logic mr);
        step_t s;
        s.exp = e;
        s.mr  = mr;
        tr.push_back(s);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected trace for one instruction: fetch waits, fetch, decode, then the
    // class-specific tail. mem_ready is random wherever it must not matter.
    function automatic void build(logic [5:0] op, logic [5:0] fn, logic zf,
                                  int wf, int wm);
        outs_t v;
        tr.delete();
        v = blank(4'd0); v.req = 1'b1; v.b = 2'b01;
        for (int i = 0; i < wf; i++) push(v, 1'b0);
        v.irw = 1'b1; v.pce = 1'b1;
        push(v, 1'b1);
        v = blank(4'd1); v.b = 2'b11;
        push(v, rnd());
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25)) begin
            v = blank(4'd6); v.a = 1'b1;
            v.sel = (fn == 6'h20) ? 2'd0 : (fn == 6'h22) ? 2'd1 : (fn == 6'h24) ? 2'd2 : 2'd3;
            push(v, rnd());
            v = blank(4'd7); v.rw = 1'b1; v.rd = 1'b1;
            push(v, rnd());
        end else if (op == 6'h23 || op == 6'h2b) begin
            v = blank(4'd2); v.a = 1'b1; v.b = 2'b10;
            push(v, rnd());
            v = blank((op == 6'h23) ? 4'd3 : 4'd5);
            v.req = 1'b1; v.iod = 1'b1; v.wr = (op == 6'h2b);
            for (int i = 0; i < wm; i++) push(v, 1'b0);
            push(v, 1'b1);
            if (op == 6'h23) begin
                v = blank(4'd4); v.rw = 1'b1; v.m2r = 1'b1;
                push(v, rnd());
            end
        end else if (op == 6'h04) begin
            v = blank(4'd8); v.a = 1'b1; v.sel = 2'b01; v.pcs = 2'b01; v.pce = zf;
            push(v, rnd());
        end else if (op == 6'h02) begin
            v = blank(4'd9); v.pcs = 2'b10; v.pce = 1'b1;
            push(v, rnd());
        end else if (op == 6'h08) begin
            v = blank(4'd10); v.a = 1'b1; v.b = 2'b10;
            push(v, rnd());
            v = blank(4'd11); v.rw = 1'b1;
            push(v, rnd());
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            v = blank(4'd12); v.ill = 1'b1;
            for (int i = 0; i < 3; i++) push(v, rnd());
`endif
        end
    endfunction

    task automatic check_cycle(string name, outs_t exp);
        n_checks++;
        hist.push_back(state);
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t state=%0d actual=%h required=%h",
                     name, $time, state, act, exp);
        end
    endtask

    // Entry and exit at posedge+1.
    task automatic run(string name, logic [5:0] op, logic [5:0] fn, logic zf,
                       int wf, int wm, int nsteps);
        int n;
        build(op, fn, zf, wf, wm);
        opcode   = op;
        funct    = fn;
        zeroFlag = zf;
        hist.delete();
        n = (nsteps < 0 || nsteps > tr.size()) ? tr.size() : nsteps;
        for (int i = 0; i < n; i++) begin
            mem_ready = tr[i].mr;
            #4;
            check_cycle(name, tr[i].exp);
            @(posedge clock); #1;
        end
    endtask

    task automatic do_reset(int cycles);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_cycle("reset_async", blank(4'd0));
        for (int i = 0; i < cycles; i++) begin
            #3;
            check_cycle("reset_hold", blank(4'd0));
            @(posedge clock); #1;
        end
        reset = 1'b1;
    endtask

    task automatic pin_hist(string name, int want_len, int which);
        n_checks++;
        if (hist.size() != want_len) begin
            n_errors++;
            $display("FAIL %s_len actual=%0d required=%0d", name, hist.size(), want_len);
        end else begin
            for (int i = 0; i < want_len; i++) begin
                logic [3:0] w;
                w = (which == 0) ? want_add[i] : want_lw[i];
                n_checks++;
                if (hist[i] !== w) begin
                    n_errors++;
                    $display("FAIL %s_state[%0d] actual=%0d required=%0d", name, i, hist[i], w);
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h20;
        zeroFlag  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clock); #1;
        do_reset(2);

        run("add", 6'h00, 6'h20, 1'b0, 0, 0, -1);
        pin_hist("add_seq", 4, 0);
        run("sub", 6'h00, 6'h22, 1'b1, 0, 0, -1);
        run("and", 6'h00, 6'h24, 1'b0, 1, 0, -1);
        run("or",  6'h00, 6'h25, 1'b0, 0, 0, -1);

        run("lw_wait", 6'h23, 6'h00, 1'b0, 0, 2, -1);
        pin_hist("lw_seq", 7, 1);
        run("lw_fwait", 6'h23, 6'h11, 1'b1, 2, 0, -1);

        run("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0, -1);
        run("beq_not",   6'h04, 6'h00, 1'b0, 0, 0, -1);
        run("sw",        6'h2b, 6'h00, 1'b0, 0, 1, -1);
        run("j",         6'h02, 6'h00, 1'b0, 0, 0, -1);
        run("addi",      6'h08, 6'h3f, 1'b0, 1, 0, -1);

        run("bad_funct", 6'h00, 6'h00, 1'b0, 0, 0, -1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        do_reset(1);
`endif
        run("bad_op", 6'h3f, 6'h20, 1'b0, 0, 0, -1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        do_reset(1);
`endif
        run("after_illegal", 6'h00, 6'h22, 1'b0, 0, 0, -1);

        // Abandon a store while it waits on memory.
        run("sw_abort", 6'h2b, 6'h00, 1'b0, 0, 3, 5);
        do_reset(2);
        run("addi_after_rst", 6'h08, 6'h00, 1'b0, 0, 0, -1);
        run("lw_after_rst",   6'h23, 6'h00, 1'b0, 1, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
